// File: rtl/quad_step_generator.sv
// Quadrature step generator: emits one A/B Gray-code transition per commanded
// count at a programmable edge period, and tracks the signed position that an
// x4 decoder watching A/B would report.
// Optional index output o_z is built only when QUAD_INDEX_EN is defined.
module quad_step_generator #(
  parameter int unsigned DIV_W  = 16,
  parameter int unsigned STEP_W = 16
`ifdef QUAD_INDEX_EN
  ,
  parameter int unsigned INDEX_CPR = 400
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_cmd_valid,
  output logic                o_cmd_ready,
  input  logic [STEP_W-1:0]   i_cmd_steps,
  input  logic                i_cmd_dir,
  input  logic [DIV_W-1:0]    i_edge_period,
  input  logic                i_abort,
  output logic                o_a,
  output logic                o_b,
  output logic                o_busy,
  output logic                o_done,
  output logic signed [31:0]  o_position
`ifdef QUAD_INDEX_EN
  ,
  output logic                o_z
`endif
);

  typedef enum logic {StIdle, StRun} state_e;

  state_e              r_state;
  logic [STEP_W-1:0]   r_remaining;
  logic [DIV_W-1:0]    r_div;
  logic [DIV_W-1:0]    r_period;
  logic                r_dir;
  logic [1:0]          r_phase;
  logic                r_a;
  logic                r_b;
  logic                r_done;
  logic signed [31:0]  r_pos;

  logic                w_accept;
  logic                w_edge_due;
  logic                w_last_edge;
  logic [DIV_W-1:0]    w_period_eff;
  logic [1:0]          w_phase_nxt;

`ifdef QUAD_INDEX_EN
  localparam int unsigned IdxW = (INDEX_CPR > 1) ? $clog2(INDEX_CPR) : 1;
  logic [IdxW-1:0]     r_idx;
`endif

  // Edge scheduling and handshake decode.
  always_comb begin
    w_period_eff = (i_edge_period == '0) ? DIV_W'(1) : i_edge_period;
    w_phase_nxt  = r_dir ? (r_phase + 2'd1) : (r_phase - 2'd1);
    w_edge_due   = (r_state == StRun) && (r_div == '0) && !i_abort;
    w_last_edge  = w_edge_due && (r_remaining == STEP_W'(1));
    // Ready is also raised in the cycle the final edge is due, so a queued
    // command is taken on that same clock and edge spacing stays uniform.
    o_cmd_ready  = !i_rst && ((r_state == StIdle) || w_last_edge);
    w_accept     = i_cmd_valid && o_cmd_ready;
  end

  // Control FSM, divider, phase, position and registered outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_remaining <= '0;
      r_div       <= '0;
      r_period    <= '0;
      r_dir       <= 1'b0;
      r_phase     <= 2'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_done      <= 1'b0;
      r_pos       <= '0;
`ifdef QUAD_INDEX_EN
      r_idx       <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: ;
        StRun: begin
          if (i_abort) begin
            // Abort wins over a due edge; outputs and position freeze.
            r_state <= StIdle;
          end else if (r_div != '0) begin
            r_div <= r_div - DIV_W'(1);
          end else begin
            r_phase     <= w_phase_nxt;
            r_a         <= w_phase_nxt[1];
            r_b         <= w_phase_nxt[1] ^ w_phase_nxt[0];
            r_pos       <= r_dir ? (r_pos + 32'sd1) : (r_pos - 32'sd1);
            r_remaining <= r_remaining - STEP_W'(1);
            r_div       <= r_period - DIV_W'(1);
`ifdef QUAD_INDEX_EN
            if (r_dir) begin
              r_idx <= (r_idx == IdxW'(INDEX_CPR - 1)) ? '0 : r_idx + IdxW'(1);
            end else begin
              r_idx <= (r_idx == '0) ? IdxW'(INDEX_CPR - 1) : r_idx - IdxW'(1);
            end
`endif
            if (r_remaining == STEP_W'(1)) begin
              r_done  <= 1'b1;
              r_state <= StIdle;
            end
          end
        end
        default: r_state <= StIdle;
      endcase

      // Accept overrides the idle transition above when chained on a final edge.
      if (w_accept) begin
        if (i_cmd_steps == '0) begin
          r_done <= 1'b1;
        end else begin
          r_state     <= StRun;
          r_remaining <= i_cmd_steps;
          r_dir       <= i_cmd_dir;
          r_period    <= w_period_eff;
          r_div       <= w_period_eff - DIV_W'(1);
        end
      end
    end
  end

  assign o_a        = r_a;
  assign o_b        = r_b;
  assign o_busy     = (r_state == StRun);
  assign o_done     = r_done;
  assign o_position = r_pos;
`ifdef QUAD_INDEX_EN
  assign o_z        = (r_idx == '0);
`endif

endmodule

// File: tb/tb_quad_step_generator.sv
// Self-checking bench for quad_step_generator. A behavioural x4 decoder and a
// command-level timing model (edge k at accept + k*P) supply all expectations.
module tb_quad_step_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_dir = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] edge_period = '0;
  logic        cmd_ready, a, b, busy, done;
  logic signed [31:0] position;
`ifdef QUAD_INDEX_EN
  logic        z;
`endif

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int dec_pos = 0;
  int illegal = 0;
  int mph = 0;
  int mpos = 0;
  logic [1:0] ab_prev = 2'b00;
  int         edge_cyc[$];
  logic [1:0] edge_ab[$];
  int         done_cyc[$];

  always #5 clk = ~clk;

  quad_step_generator u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_steps  (cmd_steps),
    .i_cmd_dir    (cmd_dir),
    .i_edge_period(edge_period),
    .i_abort      (abort),
    .o_a          (a),
    .o_b          (b),
    .o_busy       (busy),
    .o_done       (done),
    .o_position   (position)
`ifdef QUAD_INDEX_EN
    ,
    .o_z          (z)
`endif
  );

  function automatic logic [1:0] ab_of(input int ph);
    case (((ph % 4) + 4) % 4)
      0: return 2'b00;
      1: return 2'b01;
      2: return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int ph_of(input logic [1:0] ab);
    case (ab)
      2'b00: return 0;
      2'b01: return 1;
      2'b11: return 2;
      default: return 3;
    endcase
  endfunction

  // Advance one clock, sample #1 later, and feed the x4 decoder model.
  task automatic tick();
    int d;
    @(posedge clk);
    #1;
    cyc++;
    if ({a, b} !== ab_prev) begin
      edge_cyc.push_back(cyc);
      edge_ab.push_back({a, b});
      d = (ph_of({a, b}) - ph_of(ab_prev) + 4) % 4;
      if (d == 1) dec_pos++;
      else if (d == 3) dec_pos--;
      else illegal++;
      ab_prev = {a, b};
    end
    if (done === 1'b1) done_cyc.push_back(cyc);
  endtask

  task automatic clear_log();
    edge_cyc.delete();
    edge_ab.delete();
    done_cyc.delete();
  endtask

  task automatic model_reset();
    mph = 0;
    mpos = 0;
    dec_pos = 0;
    ab_prev = 2'b00;
    clear_log();
  endtask

  // Wait (bounded) for ready, offer one command, return accept cycle.
  task automatic issue(input int steps, input bit dir, input int per, output int acc);
    int guard;
    guard = 0;
    while (cmd_ready !== 1'b1 && guard < 2000) begin
      tick();
      guard++;
    end
    total++;
    if (guard >= 2000) begin
      bad++;
      $display("FAIL issue_ready_timeout got=%b exp=1", cmd_ready);
    end
    cmd_valid   = 1'b1;
    cmd_steps   = 16'(steps);
    cmd_dir     = dir;
    edge_period = 16'(per);
    tick();
    acc = cyc;
    cmd_valid   = 1'b0;
    // Scramble mid-command inputs; they must be ignored.
    cmd_dir     = 1'($urandom);
    edge_period = 16'($urandom_range(0, 7));
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    cmd_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", cmd_ready); end
    total++; if ({a, b, busy, done} !== 4'b0) begin bad++; $display("FAIL rst_outs got=%b exp=0000", {a, b, busy, done}); end
    total++; if (position !== 32'sd0) begin bad++; $display("FAIL rst_pos got=%0d exp=0", position); end
    cmd_valid = 1'b0;
    cmd_steps = 16'd3;
    rst = 1'b0;
    model_reset();
    tick();
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", cmd_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_release_busy got=%b exp=0", busy); end
`ifdef QUAD_INDEX_EN
    total++; if (z !== 1'b1) begin bad++; $display("FAIL rst_z got=%b exp=1", z); end
`endif
  endtask

  task automatic test_basic();
    int acc;
    clear_log();
    issue(8, 1'b1, 3, acc);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy); end
    repeat (26) tick();
    total++; if (edge_cyc.size() != 8) begin bad++; $display("FAIL basic_edges got=%0d exp=8", edge_cyc.size()); end
    for (int i = 0; i < 8 && i < edge_cyc.size(); i++) begin
      total++;
      if (edge_cyc[i] != acc + 3 * (i + 1) || edge_ab[i] !== ab_of(mph + i + 1)) begin
        bad++;
        $display("FAIL basic_edge%0d got=@%0d %b exp=@%0d %b", i, edge_cyc[i], edge_ab[i],
                 acc + 3 * (i + 1), ab_of(mph + i + 1));
      end
    end
    total++;
    if (done_cyc.size() != 1 || done_cyc[0] != acc + 24) begin
      bad++;
      $display("FAIL basic_done got=n%0d@%0d exp=n1@%0d", done_cyc.size(),
               (done_cyc.size() > 0) ? done_cyc[0] : -1, acc + 24);
    end
    mph += 8;
    mpos += 8;
    total++; if (position !== mpos) begin bad++; $display("FAIL basic_pos got=%0d exp=%0d", position, mpos); end
  endtask

  task automatic test_zero_steps();
    int acc;
    clear_log();
    issue(0, 1'b1, 5, acc);
    total++; if (done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL zero_done got=%b%b exp=10", done, busy); end
    repeat (6) tick();
    total++; if (edge_cyc.size() != 0) begin bad++; $display("FAIL zero_edges got=%0d exp=0", edge_cyc.size()); end
    total++; if (done_cyc.size() != 1) begin bad++; $display("FAIL zero_done_count got=%0d exp=1", done_cyc.size()); end
    total++; if ({a, b} !== ab_of(mph)) begin bad++; $display("FAIL zero_ab got=%b exp=%b", {a, b}, ab_of(mph)); end
  endtask

  task automatic test_back_to_back();
    int acc1, acc2, guard;
    bit rdy;
    clear_log();
    issue(5, 1'b1, 2, acc1);
    cmd_valid = 1'b1; cmd_steps = 16'd5; cmd_dir = 1'b0; edge_period = 16'd2;
    guard = 0;
    acc2 = -1;
    while (guard < 40) begin
      rdy = cmd_ready;
      tick();
      guard++;
      if (rdy) begin acc2 = cyc; break; end
    end
    cmd_valid = 1'b0;
    repeat (14) tick();
    total++; if (acc2 != acc1 + 10) begin bad++; $display("FAIL b2b_accept got=%0d exp=%0d", acc2, acc1 + 10); end
    total++; if (edge_cyc.size() != 10) begin bad++; $display("FAIL b2b_edges got=%0d exp=10", edge_cyc.size()); end
    for (int i = 0; i < 10 && i < edge_cyc.size(); i++) begin
      total++;
      if (edge_cyc[i] != acc1 + 2 * (i + 1) || edge_ab[i] !== ab_of((i < 5) ? mph + i + 1 : mph + 9 - i)) begin
        bad++;
        $display("FAIL b2b_edge%0d got=@%0d %b exp=@%0d %b", i, edge_cyc[i], edge_ab[i],
                 acc1 + 2 * (i + 1), ab_of((i < 5) ? mph + i + 1 : mph + 9 - i));
      end
    end
    total++;
    if (done_cyc.size() != 2 || done_cyc[0] != acc1 + 10 || done_cyc[1] != acc1 + 20) begin
      bad++;
      $display("FAIL b2b_done got=n%0d exp=n2@%0d,%0d", done_cyc.size(), acc1 + 10, acc1 + 20);
    end
    total++; if (position !== mpos) begin bad++; $display("FAIL b2b_pos got=%0d exp=%0d", position, mpos); end
  endtask

  task automatic test_random();
    int acc, n, p, per;
    bit dir;
    int exp_cyc[$];
    logic [1:0] exp_ab[$];
    int exp_done[$];
    clear_log();
    for (int c = 0; c < 8; c++) begin
      repeat ($urandom_range(0, 3)) tick();
      n = $urandom_range(0, 7);
      per = $urandom_range(0, 4);
      dir = 1'($urandom);
      p = (per == 0) ? 1 : per;
      issue(n, dir, per, acc);
      for (int i = 1; i <= n; i++) begin
        mph += dir ? 1 : -1;
        mpos += dir ? 1 : -1;
        exp_cyc.push_back(acc + p * i);
        exp_ab.push_back(ab_of(mph));
      end
      exp_done.push_back(acc + n * p);
      while (cyc < acc + n * p) tick();
    end
    repeat (2) tick();
    total++; if (edge_cyc.size() != exp_cyc.size()) begin bad++; $display("FAIL rnd_edges got=%0d exp=%0d", edge_cyc.size(), exp_cyc.size()); end
    for (int i = 0; i < exp_cyc.size() && i < edge_cyc.size(); i++) begin
      total++;
      if (edge_cyc[i] != exp_cyc[i] || edge_ab[i] !== exp_ab[i]) begin
        bad++;
        $display("FAIL rnd_edge%0d got=@%0d %b exp=@%0d %b", i, edge_cyc[i], edge_ab[i], exp_cyc[i], exp_ab[i]);
      end
    end
    total++; if (done_cyc != exp_done) begin bad++; $display("FAIL rnd_done got=n%0d exp=n%0d", done_cyc.size(), exp_done.size()); end
    total++; if (position !== mpos || dec_pos != mpos) begin bad++; $display("FAIL rnd_pos got=%0d/%0d exp=%0d", position, dec_pos, mpos); end
    total++; if (illegal != 0) begin bad++; $display("FAIL rnd_illegal got=%0d exp=0", illegal); end
  endtask

  task automatic test_abort();
    int acc, acc2;
    clear_log();
    issue(20, 1'b1, 2, acc);
    while (cyc < acc + 9) tick();
    abort = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL abort_ready_during got=%b exp=0", cmd_ready); end
    tick();
    abort = 1'b0;
    mph += 4;
    mpos += 4;
    total++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL abort_idle got=%b%b exp=01", busy, cmd_ready); end
    repeat (10) tick();
    total++; if (edge_cyc.size() != 4) begin bad++; $display("FAIL abort_edges got=%0d exp=4", edge_cyc.size()); end
    total++; if (done_cyc.size() != 0) begin bad++; $display("FAIL abort_nodone got=%0d exp=0", done_cyc.size()); end
    total++; if (position !== mpos || {a, b} !== ab_of(mph)) begin bad++; $display("FAIL abort_hold got=%0d %b exp=%0d %b", position, {a, b}, mpos, ab_of(mph)); end
    // Abort while idle is ignored; the simultaneous command goes through.
    clear_log();
    abort = 1'b1; cmd_valid = 1'b1; cmd_steps = 16'd2; cmd_dir = 1'b0; edge_period = 16'd1;
    tick();
    acc2 = cyc;
    cmd_valid = 1'b0; abort = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_idle_accept got=%b exp=1", busy); end
    repeat (4) tick();
    mph -= 2;
    mpos -= 2;
    total++; if (position !== mpos) begin bad++; $display("FAIL abort_idle_pos got=%0d exp=%0d", position, mpos); end
    total++; if (done_cyc.size() != 1 || done_cyc[0] != acc2 + 2) begin bad++; $display("FAIL abort_idle_done got=n%0d exp=@%0d", done_cyc.size(), acc2 + 2); end
  endtask

  task automatic test_reset_mid();
    int acc;
    clear_log();
    issue(10, 1'b1, 3, acc);
    repeat (7) tick();
    total++; if (position !== mpos + 2) begin bad++; $display("FAIL rstmid_pre got=%0d exp=%0d", position, mpos + 2); end
    #2 rst = 1'b1;
    #1;
    total++; if (position !== 32'sd0) begin bad++; $display("FAIL rstmid_pos got=%0d exp=0", position); end
    total++; if ({a, b, busy, done, cmd_ready} !== 5'b0) begin bad++; $display("FAIL rstmid_outs got=%b exp=00000", {a, b, busy, done, cmd_ready}); end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    repeat (30) tick();
    total++; if (edge_cyc.size() != 0 || busy !== 1'b0) begin bad++; $display("FAIL rstmid_discard got=%0d %b exp=0 0", edge_cyc.size(), busy); end
  endtask

  task automatic test_loopback();
    int acc;
    clear_log();
    issue(400, 1'b1, 4, acc);
    while (cyc < acc + 1600) tick();
    mpos += 400;
    total++; if (position !== mpos || dec_pos != mpos) begin bad++; $display("FAIL loop_fwd got=%0d/%0d exp=%0d", position, dec_pos, mpos); end
    issue(400, 1'b0, 4, acc);
    while (cyc < acc + 1600) tick();
    mpos -= 400;
    total++; if (position !== 32'sd0 || dec_pos != 0) begin bad++; $display("FAIL loop_rev got=%0d/%0d exp=0", position, dec_pos); end
    total++; if (done_cyc.size() != 2 || illegal != 0) begin bad++; $display("FAIL loop_misc got=n%0d ill%0d exp=n2 ill0", done_cyc.size(), illegal); end
  endtask

`ifdef QUAD_INDEX_EN
  task automatic test_index();
    int acc;
    #1 rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    issue(400, 1'b1, 1, acc);
    total++; if (z !== 1'b1) begin bad++; $display("FAIL idx_start got=%b exp=1", z); end
    for (int i = 1; i <= 400; i++) begin
      tick();
      total++;
      if (z !== ((i % 400) == 0)) begin bad++; $display("FAIL idx_fwd%0d got=%b exp=%b", i, z, (i % 400) == 0); end
    end
    #1 rst = 1'b1;
    #1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    issue(1, 1'b0, 1, acc);
    tick();
    total++; if (z !== 1'b0 || u_dut.r_idx != 399) begin bad++; $display("FAIL idx_rev got=%b %0d exp=0 399", z, u_dut.r_idx); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_zero_steps();
    test_back_to_back();
    test_random();
    test_abort();
    test_reset_mid();
    test_loopback();
`ifdef QUAD_INDEX_EN
    test_index();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/quad_step_generator.md
# quad_step_generator

Quadrature encoder emulator: accepts step commands over a valid/ready handshake and drives A/B quadrature outputs with a programmable edge period, producing exactly one A/B transition per commanded count. It is the transmit-side counterpart of the x4 quadrature decoder. It drives that decoder in loopback benches and emulates a motor encoder in hardware-in-the-loop setups. It keeps its own signed position count, which must always equal the count a correct x4 decoder reports.

## Interface
- DIV_W, 16, width of edge_period and of the internal divider counter
- STEP_W, 16, width of cmd_steps
- INDEX_CPR, 400, counts per revolution for the index output (used only with QUAD_INDEX_EN)

- clk  in  1  system clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  generator idle; can accept a command
- cmd_steps  in  STEP_W  number of A/B edges (x4 counts) to emit
- cmd_dir  in  1  1 = forward, 0 = reverse
- edge_period  in  DIV_W  clock cycles between edges; 0 is treated as 1; sampled at accept
- abort  in  1  stop the current command
- A  out  1  quadrature channel A (registered)
- B  out  1  quadrature channel B (registered)
- busy  out  1  command in progress
- done  out  1  one-cycle pulse when a command completes normally
- position  out  signed 32  running count of emitted edges
- Z  out  1  index output; present only with QUAD_INDEX_EN

## Operation
- Phase sequence, as {A,B}:
  - Forward: 00→01→11→10→00.
  - Reverse: 00→10→11→01→00.
  - Phase is a 2-bit state: 0:00, 1:01, 2:11, 3:10. Forward does +1 mod 4, reverse does −1 mod 4.
  - Only one of A/B changes per edge.
- Per edge, position changes by +1 (forward) or −1 (reverse). It wraps in two's complement with no saturation.
- FSM states are IDLE and RUN.
- IDLE:
  - cmd_ready = 1 (forced 0 while rst is high); busy = 0.
  - An accept is cmd_valid && cmd_ready.
  - On accept with cmd_steps = 0: stay in IDLE and pulse done the next cycle, with no edges.
  - On accept with cmd_steps > 0: latch remaining = cmd_steps, dir = cmd_dir, and P = max(edge_period, 1); load divider = P−1; go to RUN.
- RUN:
  - busy = 1; cmd_ready = 0.
  - While divider ≠ 0, the divider decrements each cycle.
  - When divider = 0: advance the phase, update position, decrement remaining, and reload divider = P−1.
  - When the final edge is emitted (remaining = 1), go to IDLE.
  - Mid-command changes to cmd_dir and edge_period are ignored.
- abort:
  - Honoured only in RUN. It has priority over an edge due in the same cycle, so that edge is suppressed.
  - The generator goes to IDLE. A, B and position hold their current values and done is not pulsed.
  - In IDLE, abort is ignored; a simultaneous cmd_valid is accepted normally.
- Reset clears A, B, phase, position, remaining, divider, busy and done to 0 and puts the FSM in IDLE. Reset mid-command discards the command.

## Timing
- Accept at rising edge k: busy = 1 from cycle k+1.
- The first A/B change is visible after edge k+P. Later edges follow every P cycles.
- On the last edge, A/B, position, done = 1 and cmd_ready = 1 all appear in the same cycle.
- A command accepted in that same cycle emits its first edge P cycles later. Back-to-back commands therefore keep uniform spacing with no dead cycle.
- A command of N steps occupies N·P cycles from accept to done.
- position updates in the same cycle as its A/B edge, with zero latency relative to A/B.
- The maximum edge rate is 1 edge/clk (P = 1). The downstream decoder's synchroniser must tolerate this; benches use P ≥ 4 for decoder loopback.

## Configuration
- QUAD_INDEX_EN defined:
  - An idx counter runs 0..INDEX_CPR−1. It increments mod INDEX_CPR on forward edges and decrements mod INDEX_CPR on reverse edges.
  - Z = (idx == 0), taken from the register. Reset value of idx is 0, so Z = 1 out of reset.
  - Abort holds idx with the rest of the state.
- QUAD_INDEX_EN undefined: the Z port, the idx counter and the INDEX_CPR logic are absent. All other behaviour is identical.

## Test plan
- Reset, then a command of steps = 8, dir = 1, period = 3:
  - A/B go 01,11,10,00,01,11,10,00, each 3 cycles apart; the first change comes 3 cycles after accept.
  - position = 8; done is a single pulse, coincident with the 8th edge; the command lasts 24 cycles from accept to done.
- Loopback into the decoder: 400 forward then 400 reverse at period 4 → decoder position equals generator position after each command; final value 0.
- Back-to-back commands, 5 forward then 5 reverse, period 2, with cmd_valid held high → the second is accepted in the done cycle; edge spacing is exactly 2 throughout; final position = 0.
- Abort at cycle 10 of a 20-step, period-2 command, coincident with a due edge → that edge is suppressed; position = 4; no done; cmd_ready = 1 the next cycle.
- Edge cases:
  - period = 0 with 4 steps → edges on consecutive cycles.
  - steps = 0 → done one cycle after accept; A/B unchanged.
  - rst asserted mid-command → all outputs are 0 immediately, without waiting for a clock.
- With QUAD_INDEX_EN and INDEX_CPR = 400:
  - From reset, 400 forward steps → Z drops at the first edge and returns high at edge 400.
  - 1 reverse step from reset → idx = 399, Z = 0.
